vga_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing.sv | 55 +++++
 rtl/vga_scanout.sv | 97 +++++++++
 tb/tb_vga_scanout.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 VGA timing, 160x120 framebuffer geometry and shared colour codes
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_ADDR_W = 15;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_FLOOR = 3'b101;
    localparam logic [2:0] COLOR_TREE  = 3'b110;
    localparam logic [2:0] COLOR_MAN   = 3'b111;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel divider, h/v scan counters, raw sync/visible flags and vblank_start strobe
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       pix_en,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       hs,
    output logic       vs,
    output logic       vis,
    output logic       vblank_start
);

    localparam logic PH_LAST = 1'(CLK_DIV - 1);

    logic       ph;
    logic [9:0] h;
    logic [9:0] v;
    logic       h_last;
    logic       v_last;

    assign h_last = h == 10'(H_TOTAL - 1);
    assign v_last = v == 10'(V_TOTAL - 1);

    // pix_en is registered so it is low in reset and first rises CLK_DIV clks after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph           <= 1'b0;
            pix_en       <= 1'b0;
            h            <= '0;
            v            <= '0;
            vblank_start <= 1'b0;
        end else begin
            ph           <= (ph == PH_LAST) ? 1'b0 : ph + 1'b1;
            pix_en       <= ph == PH_LAST;
            vblank_start <= pix_en && h_last && v == 10'(V_VISIBLE - 1);
            if (pix_en) begin
                h <= h_last ? 10'd0 : h + 10'd1;
                if (h_last)
                    v <= v_last ? 10'd0 : v + 10'd1;
            end
        end
    end

    assign x   = h[9:2];
    assign y   = v[8:2];
    assign hs  = (h >= 10'(H_VISIBLE + H_FP)) && (h < 10'(H_VISIBLE + H_FP + H_SYNC));
    assign vs  = (v >= 10'(V_VISIBLE + V_FP)) && (v < 10'(V_VISIBLE + V_FP + V_SYNC));
    assign vis = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer scan-out to 640x480 VGA with 4x4 replication; SCANOUT_TESTPATTERN_EN selects colour bars
module vga_scanout
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [2:0]           fb_rdata,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 vga_hs_n,
    output logic                 vga_vs_n,
    output logic                 vga_blank_n,
    output logic                 vga_pix_en,
    output logic                 vblank_start
);

    logic       pix_en;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       hs_d;
    logic       vs_d;
    logic       vis_d;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] src;
    logic [2:0] rgb;

    vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
        .clk          (clk),
        .reset_n      (reset_n),
        .pix_en       (pix_en),
        .x            (x),
        .y            (y),
        .hs           (hs),
        .vs           (vs),
        .vis          (vis),
        .vblank_start (vblank_start)
    );

`ifdef SCANOUT_TESTPATTERN_EN
    logic [7:0] x_d;

    // column travels with the stage-1 flags so the bar index lines up with blanking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            x_d <= '0;
        else if (pix_en)
            x_d <= x;
    end

    assign src = 3'(x_d / 8'd20);
`else
    assign src = fb_rdata;
`endif

    // stage 1: issue the RAM address (y*160 + x) and delay the raw flags to match the read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_addr <= '0;
            hs_d    <= 1'b0;
            vs_d    <= 1'b0;
            vis_d   <= 1'b0;
        end else if (pix_en) begin
            hs_d  <= hs;
            vs_d  <= vs;
            vis_d <= vis;
            if (vis)
                fb_addr <= {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
        end
    end

    // stage 2: capture colour and drive sync/blank, all aligned to the same pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb         <= '0;
            vga_hs_n    <= 1'b1;
            vga_vs_n    <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            rgb         <= vis_d ? src : 3'b000;
            vga_hs_n    <= ~hs_d;
            vga_vs_n    <= ~vs_d;
            vga_blank_n <= vis_d;
        end
    end

    assign vga_r      = {8{rgb[2]}};
    assign vga_g      = {8{rgb[1]}};
    assign vga_b      = {8{rgb[0]}};
    assign vga_pix_en = pix_en;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: closed-form scan model checked every cycle, plus literal timing/address/colour pins
module tb_vga_scanout;

    localparam int D     = 2;
    localparam int FRAME = 800 * 525;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] fb_addr;
    logic [2:0]  fb_rdata = 3'b000;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs_n, vga_vs_n, vga_blank_n, vga_pix_en, vblank_start;

    logic [2:0]  mem [0:19199];
    int          e = 0;
    int          checks = 0;
    int          failures = 0;
    bit          run = 1'b0;
    bit          prev_hs = 1'b1;
    int          nfalls = 0;
    int          fall_e = 0;

    vga_scanout #(.CLK_DIV(D)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fb_addr      (fb_addr),
        .fb_rdata     (fb_rdata),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hs_n     (vga_hs_n),
        .vga_vs_n     (vga_vs_n),
        .vga_blank_n  (vga_blank_n),
        .vga_pix_en   (vga_pix_en),
        .vblank_start (vblank_start)
    );

    always #5 clk = ~clk;

    // synchronous RAM, one clk of read latency
    always @(posedge clk) fb_rdata <= mem[fb_addr];

    // clk edges since reset release
    always @(posedge clk or negedge reset_n)
        if (!reset_n) e <= 0;
        else e <= e + 1;

    function automatic logic [14:0] addr_of(input int h, input int v);
        return 15'((v / 4) * 160 + h / 4);
    endfunction

    // expected {fb_addr, r, g, b, hs_n, vs_n, blank_n, pix_en, vblank_start} after edge n
    function automatic logic [43:0] model(input int n);
        int p, t, h, v;
        logic [14:0] a;
        logic [2:0]  c;
        logic hsn, vsn, bn, pe, vb;
        pe = n >= 1 && n % D == 0;
        p  = n >= 1 ? (n - 1) / D : 0;
        vb = n >= 2 && (n - 1) % D == 0 && p % FRAME == 800 * 480;
        a  = 15'd0;
        if (p >= 1) begin
            t = (p - 1) % FRAME;
            h = t % 800;
            v = t / 800;
            a = v >= 480 ? 15'd19199 : addr_of(h < 640 ? h : 639, v);
        end
        hsn = 1'b1; vsn = 1'b1; bn = 1'b0; c = 3'b000;
        if (p >= 2) begin
            t   = (p - 2) % FRAME;
            h   = t % 800;
            v   = t / 800;
            bn  = h < 640 && v < 480;
            hsn = !(h >= 656 && h < 752);
            vsn = !(v >= 490 && v < 492);
            c   = bn ? mem[addr_of(h, v)] : 3'b000;
        end
        return {a, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hsn, vsn, bn, pe, vb};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, req, e);
        end
    endtask

    // per-cycle comparison against the model, plus literal pins and hs_n edge timing
    always @(negedge clk) begin
        if (run) begin
            chk("scan", {fb_addr, vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, vga_blank_n, vga_pix_en, vblank_start}, model(e));
            if (!reset_n) begin
                prev_hs = 1'b1;
                nfalls  = 0;
            end else begin
                if (e == 1) chk("pix_en_e1", vga_pix_en, 1'b0);
                if (e == 2) chk("pix_en_e2", vga_pix_en, 1'b1);
                if (e == 9) chk("addr_3_0", fb_addr, 15'd0);
                if (e == 6411) chk("addr_4_4", fb_addr, 15'd161);
                if (e == 6413) chk("rgb_4_4", {vga_r, vga_g, vga_b}, 24'hFFFF00);
                if (e == 11219) chk("rgb_7_7", {vga_r, vga_g, vga_b}, 24'hFFFF00);
                if (prev_hs && !vga_hs_n) begin
                    if (nfalls == 0) chk("hs_first_fall", e, 1317);
                    else chk("hs_period", e - fall_e, 1600);
                    fall_e = e;
                    nfalls++;
                end
                if (!prev_hs && vga_hs_n) chk("hs_width", e - fall_e, 192);
                prev_hs = vga_hs_n;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
        for (int yy = 0; yy < 120; yy++) mem[yy * 160 + 159] = 3'b111;
        mem[161] = 3'b110;
        repeat (3) @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (30000 + $urandom_range(0, 1599)) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", {fb_addr, vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, vga_blank_n, vga_pix_en, vblank_start},
               {15'd0, 24'd0, 5'b11000});
        repeat ($urandom_range(1, 5)) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (50000) @(negedge clk);
        chk("hs_fall_count", nfalls, 31);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
